// File: rtl/key_pkg.sv
// Shared types and defaults for the key event arbiter.
package key_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StGap
  } state_e;

  localparam int unsigned GapDefault  = 16;
  localparam int unsigned CntWDefault = 8;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after index last, wrapping.
module rr_arbiter
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS = 4,
  parameter int unsigned ID_W   = idx_width(N_KEYS)
) (
  input  logic [N_KEYS-1:0] req,
  input  logic [ID_W-1:0]   last,
  output logic [ID_W-1:0]   gnt_id,
  output logic              any
);

  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    for (int unsigned k = 1; k <= N_KEYS; k++) begin
      automatic int unsigned idx = (32'(last) + k) % N_KEYS;
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Queues debounced key pulses and serves them one at a time over valid/ready,
// round-robin among pending keys, with an idle gap and a saturating overrun count.
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS = 4,
  parameter int unsigned GAP    = GapDefault,
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned ID_W   = idx_width(N_KEYS)
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic              overrun,
  output logic [CNT_W-1:0]  overrun_cnt,
  input  logic              clr_ovr
);

  localparam int unsigned GapW = idx_width(GAP + 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP == 0) ? 0 : GAP - 1);
  localparam int unsigned SumW = CNT_W + ID_W + 1;
  localparam logic [SumW-1:0] CntMax = {{(SumW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  state_e            state_q, state_d;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              valid_q, valid_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic [N_KEYS-1:0] gnt_mask;
  logic [N_KEYS-1:0] ovr_bits;
  logic [SumW-1:0]   n_ovr;
  logic [SumW-1:0]   cnt_sum;
  logic              hs;

  rr_arbiter #(
    .N_KEYS (N_KEYS),
    .ID_W   (ID_W)
  ) u_rr (
    .req    (pending_q),
    .last   (last_q),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    gap_d    = gap_q;
    gnt_mask = '0;
    hs       = valid_q && evt_ready;

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          gnt_mask[gnt_id] = 1'b1;
          id_d             = gnt_id;
          state_d          = StOffer;
        end
      end
      StOffer: begin
        if (hs) begin
          last_d  = id_q;
          gap_d   = '0;
          state_d = (GAP > 0) ? StGap : StIdle;
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Valid trails entry into OFFER by one cycle and drops on the handshake edge.
    valid_d = (state_q == StOffer) && !hs;

    // A pulse on the key being granted this cycle re-arms it instead of overrunning.
    ovr_bits  = key_en & pending_q & ~gnt_mask;
    pending_d = (pending_q & ~gnt_mask) | key_en;

    n_ovr = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      n_ovr = n_ovr + SumW'(ovr_bits[i]);
    end
    cnt_sum = (clr_ovr ? '0 : SumW'(cnt_q)) + n_ovr;
    cnt_d   = (cnt_sum > CntMax) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    ovr_d   = (ovr_q && !clr_ovr) || (|ovr_bits);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      last_q    <= ID_W'(N_KEYS - 1);
      id_q      <= '0;
      valid_q   <= 1'b0;
      gap_q     <= '0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      gap_q     <= gap_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_id      = id_q;
  assign overrun     = ovr_q;
  assign overrun_cnt = cnt_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Randomized and directed bench for key_event_arbiter against a timing-level reference model.
module tb_key_event_arbiter;

  localparam int NK = 4;
  localparam int GP = 4;
  localparam int CW = 8;
  localparam int CntMax = (1 << CW) - 1;

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_en = '0;
  logic          evt_ready = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic          overrun;
  logic [CW-1:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: pending set, last winner, earliest edge a new grant may happen.
  bit [NK-1:0] m_pend;
  int          m_last, m_id, m_cnt, m_next;
  bit          m_busy, m_vis, m_ovr;
  int          ecnt = 0;

  int ev_id[$];
  int ev_edge[$];

  key_event_arbiter #(
    .N_KEYS (NK),
    .GAP    (GP),
    .CNT_W  (CW)
  ) dut (
    .mclk        (mclk),
    .rst         (rst),
    .key_en      (key_en),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt),
    .clr_ovr     (clr_ovr)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input bit [NK-1:0] k, input bit rdy, input bit clr, input bit r);
    bit [NK-1:0] gm;
    int n;
    ecnt++;
    if (r) begin
      m_pend = '0; m_last = NK - 1; m_id = 0; m_cnt = 0; m_ovr = 0;
      m_busy = 0; m_vis = 0; m_next = ecnt + 1;
      return;
    end
    gm = '0;
    if (m_vis && rdy) begin
      m_last = m_id; m_vis = 0; m_busy = 0; m_next = ecnt + GP + 1;
    end else if (m_busy && !m_vis) begin
      m_vis = 1;
    end else if (!m_busy && ecnt >= m_next && m_pend != 0) begin
      for (int j = 1; j <= NK; j++) begin
        int idx;
        idx = (m_last + j) % NK;
        if (m_pend[idx]) begin
          m_id = idx;
          break;
        end
      end
      m_busy = 1;
      gm[m_id] = 1'b1;
    end
    n = $countones(k & m_pend & ~gm);
    if (clr) begin
      m_cnt = 0; m_ovr = 0;
    end
    if (n > 0) begin
      m_ovr = 1;
      m_cnt = (m_cnt + n > CntMax) ? CntMax : m_cnt + n;
    end
    m_pend = (m_pend & ~gm) | k;
  endtask

  task automatic cycle(input bit [NK-1:0] k, input bit rdy, input bit clr, input bit r);
    key_en = k; evt_ready = rdy; clr_ovr = clr; rst = r;
    if (!r && evt_valid === 1'b1 && rdy) begin
      ev_id.push_back(int'(evt_id));
      ev_edge.push_back(ecnt + 1);
    end
    @(posedge mclk);
    model_step(k, rdy, clr, r);
    @(negedge mclk);
    chk("valid", int'(evt_valid), int'(m_vis));
    chk("id", int'(evt_id), m_id);
    chk("ovr", int'(overrun), int'(m_ovr));
    chk("ovr_cnt", int'(overrun_cnt), m_cnt);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b0, 1'b1);
    ev_id.delete();
    ev_edge.delete();
  endtask

  initial begin
    int t;

    // Reset state and single-event latency.
    do_reset();
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_cnt", int'(overrun_cnt), 0);
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    t = ecnt;
    for (int i = 0; i < 8; i++) cycle('0, 1'b1, 1'b0, 1'b0);
    chk("lat_count", ev_id.size(), 1);
    if (ev_id.size() == 1) begin
      chk("lat_id", ev_id[0], 2);
      chk("lat_edge", ev_edge[0], t + 3);
    end

    // Round-robin from reset with all keys at once.
    do_reset();
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle('0, 1'b1, 1'b0, 1'b0);
    chk("rr_count", ev_id.size(), 4);
    if (ev_id.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rr_id", ev_id[i], i);
      // Handshake at h, next offer visible after edge h+GAP+2, accepted one edge later.
      for (int i = 0; i < 3; i++) chk("rr_gap", ev_edge[i + 1] - 1 - ev_edge[i], GP + 2);
    end

    // Stall on key 1.
    do_reset();
    cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    chk("stall_valid", int'(evt_valid), 1);
    chk("stall_id", int'(evt_id), 1);
    for (int i = 0; i < 12; i++) cycle('0, 1'b1, 1'b0, 1'b0);
    chk("stall_count", ev_id.size(), 1);

    // Overrun, saturation, and clear coinciding with an overrun.
    do_reset();
    cycle(4'b1001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("ovr_one_flag", int'(overrun), 1);
    chk("ovr_one_cnt", int'(overrun_cnt), 1);
    for (int i = 0; i < 300; i++) cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("ovr_sat", int'(overrun_cnt), CntMax);
    cycle(4'b1000, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr_cnt", int'(overrun_cnt), 1);
    chk("ovr_clr_flag", int'(overrun), 1);

    // Re-arm on the grant edge.
    do_reset();
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cycle('0, 1'b1, 1'b0, 1'b0);
    chk("rearm_count", ev_id.size(), 2);
    if (ev_id.size() == 2) chk("rearm_id", ev_id[1], 2);
    chk("rearm_ovr", int'(overrun), 0);

    // Reset while offering with two keys still pending.
    do_reset();
    cycle(4'b0111, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    chk("mid_valid_pre", int'(evt_valid), 1);
    cycle('0, 1'b0, 1'b0, 1'b1);
    chk("mid_valid_rst", int'(evt_valid), 0);
    ev_id.delete();
    ev_edge.delete();
    for (int i = 0; i < 30; i++) cycle('0, 1'b1, 1'b0, 1'b0);
    chk("mid_stale", ev_id.size(), 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit [NK-1:0] k;
      k = NK'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      cycle(k, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got %0d want %0d", ecnt, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Collects single-cycle debounced key pulses (the `key_en` outputs of the key debouncer) and serves them one at a time to a downstream consumer over a valid/ready handshake. Grants among simultaneously pending keys are round-robin. A minimum idle gap separates consecutive events, and a saturating counter tracks pulses lost to overrun. It sits between the key debouncer and any menu or control FSM that consumes key events.

## Interface

**Parameters**
- `N_KEYS`, 4: number of key inputs; must be at least 2.
- `GAP`, 16: idle cycles inserted after each accepted event; 0 is legal.
- `CNT_W`, 8: width of the overrun counter.
- `ID_W`, `$clog2(N_KEYS)`: width of the key index; derived, not overridden.

**Ports**
- `mclk`, input, 1: the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `key_en`, input, `N_KEYS`: one-cycle press pulses, one bit per key; any combination may arrive in the same cycle.
- `evt_valid`, output, 1: an event is offered.
- `evt_ready`, input, 1: the consumer accepts the offered event.
- `evt_id`, output, `ID_W`: index of the offered key.
- `overrun`, output, 1: sticky; at least one pulse has been lost.
- `overrun_cnt`, output, `CNT_W`: number of lost pulses; saturates at all-ones.
- `clr_ovr`, input, 1: clears `overrun` and `overrun_cnt`.

## Operation

- **`pending` vector.** Bit `i` is set on the edge where `key_en[i]` is sampled high. It is cleared when key `i` is granted.
- **Overrun.** A pulse on key `i` while `pending[i]` is already 1 is an overrun:
  - the pulse is dropped;
  - `overrun` is set to 1;
  - `overrun_cnt` increments by the number of overrunning bits in that cycle, saturating.
- **Re-arm on grant.** A pulse on key `i` in the same cycle that key `i` is granted is not an overrun; `pending[i]` ends at 1.
- **Overrun during an offer.** A pulse for the key currently offered is not an overrun, because its pending bit was cleared at grant.
- **Round-robin.** The search starts at `last_grant+1` (modulo `N_KEYS`). The first pending index found wins. `last_grant` updates only on handshake.
- **FSM states:**
  - IDLE: if any bit of `pending` is set, load `evt_id` with the winner, clear that pending bit, and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `evt_valid` is 1, and `evt_id` is held stable until handshake. On `evt_valid && evt_ready`, set `last_grant` to `evt_id`, then go to GAP if `GAP` > 0, else to IDLE.
  - GAP: a counter runs from 0 to `GAP-1`, then the FSM goes to IDLE. `key_en` is still captured into `pending` during GAP.
- **Clearing overrun.** `clr_ovr` zeroes `overrun` and `overrun_cnt`. If an overrun occurs in the same cycle as `clr_ovr`, the result is `overrun`=1 and `overrun_cnt` equal to the new count (the clear applies first).

## Timing

- **Reset values:** state IDLE, `pending`=0, `last_grant`=`N_KEYS-1` (so key 0 is served first), `evt_valid`=0, `evt_id`=0, `overrun`=0, `overrun_cnt`=0.
- **Reset mid-operation:** pending keys and any offered event are discarded; the FSM returns to IDLE.
- **Latency:** a `key_en` pulse sampled at edge t, with the FSM in IDLE and `pending`=0, gives `evt_valid`=1 after edge t+2.
- **Back-to-back events:** after a handshake at edge h, the next `evt_valid` rises after edge h+`GAP`+2; with `GAP`=0, it rises after edge h+2.
- **Stability:** while `evt_valid`=1 and `evt_ready`=0, `evt_id` and `evt_valid` are stable; the offer is never withdrawn.
- **Registered outputs:** all outputs are registered; there is no combinational path from input to output.

## Structure

- **Package `key_pkg`:**
  - state enum `{IDLE, OFFER, GAP}`;
  - function computing `ID_W`;
  - the default values of `GAP` and `CNT_W`.
- **Sub-module `rr_arbiter`:**
  - purely combinational;
  - inputs: `req[N_KEYS-1:0]` and `last[ID_W-1:0]`;
  - outputs: `gnt_id` and `any`.

  It is instantiated once, and the FSM, pending register, gap counter and overrun logic stay in the top level.

## Test plan

1. **Reset state.** Hold `rst`=1 for 3 cycles. All outputs read 0. With `evt_ready`=1, pulse `key_en`=4'b0100 once: `evt_valid` rises 2 edges after the pulse with `evt_id`=2 and stays high for exactly 1 cycle.
2. **Round-robin order.** With `GAP`=4 and `evt_ready`=1, pulse `key_en`=4'b1111 in a single cycle. Events arrive with `evt_id` 0, 1, 2, 3, spaced exactly 6 cycles apart.
3. **Stall.** Hold `evt_ready`=0 for 10 cycles while an event for key 1 is offered. `evt_valid` and `evt_id`=1 stay constant; accepting then produces exactly one event.
4. **Overrun.** Pulse key 3 twice while it is still pending (offer stalled on key 0). Result: `overrun`=1, `overrun_cnt`=1. Pulse it 300 times with `CNT_W`=8: `overrun_cnt` saturates at 255. Assert `clr_ovr` in the same cycle as a further overrun: `overrun_cnt`=1.
5. **Re-arm on grant.** Pulse key 2 exactly on the grant edge of key 2: a second key-2 event follows, and `overrun` stays 0.
6. **Reset mid-offer.** Assert `rst` while an event is offered with 2 keys pending. `evt_valid` is 0 on the next cycle, and no stale events appear after reset is released.
